// File: rtl/loop_mixer.sv
`default_nettype none
// ============================================================================
// Module   : loop_mixer
// Purpose  : N-channel looper mixer. Serially sums aux plus playing banks, with
//            per-bank attenuation, headroom shift and saturation to an
//            offset-binary PWM word. Optional macro: MIX_AUTOSCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module loop_mixer #(
   parameter int N_CH     = 8,
   parameter int SAMPLE_W = 16,
   parameter int PWM_W    = 11,
   parameter int GAIN_W   = 2,
   parameter int HEADROOM = 4
) (
   input  logic                                     clk_100MHz,
   input  logic                                     rst,
   input  logic                                     ch_wr,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
   input  logic [SAMPLE_W-1:0]                      ch_data,
   input  logic [N_CH-1:0]                          playing,
   input  logic [N_CH*GAIN_W-1:0]                   gain,
   input  logic [SAMPLE_W-1:0]                      aux_in,
   input  logic                                     mix_strobe,
   output logic                                     busy,
   output logic                                     mix_valid,
   output logic                                     overrun,
   output logic [PWM_W-1:0]                         pwm_out
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int ACC_W = SAMPLE_W + $clog2(N_CH + 1) + 1;
   localparam logic signed [ACC_W-1:0] c_pos_max = ACC_W'((2 ** (PWM_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] c_neg_min = ACC_W'(-(2 ** (PWM_W - 1)));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SCALE = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic signed [SAMPLE_W-1:0] r_ch [N_CH];
   logic signed [ACC_W-1:0]    r_acc;
   logic [IDX_W-1:0]           r_idx;
   logic                       r_strobe;
   logic signed [PWM_W-1:0]    r_y;
   logic                       r_valid;
   logic                       r_overrun;
   logic [PWM_W-1:0]           r_pwm;

   logic signed [SAMPLE_W-1:0] w_ch_s;
   logic signed [SAMPLE_W-1:0] w_aux_s;
   logic signed [ACC_W-1:0]    w_aux_ext;
   logic signed [SAMPLE_W-1:0] w_sel;
   logic [GAIN_W-1:0]          w_gain;
   logic signed [ACC_W-1:0]    w_sel_ext;
   logic signed [ACC_W-1:0]    w_term;
   logic signed [ACC_W-1:0]    w_y;
   logic signed [PWM_W-1:0]    w_ysat;
   int                         w_sh;

   // Offset-binary to two's complement is an MSB flip.
   assign w_ch_s    = {~ch_data[SAMPLE_W-1], ch_data[SAMPLE_W-2:0]};
   assign w_aux_s   = {~aux_in[SAMPLE_W-1], aux_in[SAMPLE_W-2:0]};
   assign w_aux_ext = {{(ACC_W-SAMPLE_W){w_aux_s[SAMPLE_W-1]}}, w_aux_s};

   always_comb begin
      w_sel  = '0;
      w_gain = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_sel  = r_ch[k];
            w_gain = gain[k*GAIN_W +: GAIN_W];
         end
      end
   end

   assign w_sel_ext = {{(ACC_W-SAMPLE_W){w_sel[SAMPLE_W-1]}}, w_sel};
   assign w_term    = w_sel_ext >>> w_gain;

`ifdef MIX_AUTOSCALE_EN
   int w_pc;
   always_comb begin
      w_pc = 0;
      for (int k = 0; k < N_CH; k++) begin
         w_pc = w_pc + int'(playing[k]);
      end
      w_sh = SAMPLE_W - PWM_W;
      for (int b = 0; b < 5; b++) begin
         if ((1 << b) < (w_pc + 1)) begin
            w_sh = SAMPLE_W - PWM_W + b + 1;
         end
      end
   end
`else
   assign w_sh = SAMPLE_W - PWM_W + HEADROOM;
`endif

   assign w_y = r_acc >>> w_sh;

   always_comb begin
      w_ysat = w_y[PWM_W-1:0];
      if (w_y > c_pos_max) begin
         w_ysat = {1'b0, {(PWM_W-1){1'b1}}};
      end else if (w_y < c_neg_min) begin
         w_ysat = {1'b1, {(PWM_W-1){1'b0}}};
      end
   end

   // A non-playing bank is held at zero even against a simultaneous write.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) begin
            r_ch[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (!playing[k]) begin
               r_ch[k] <= '0;
            end else if (ch_wr && (ch_sel == IDX_W'(k))) begin
               r_ch[k] <= w_ch_s;
            end
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_strobe) w_next = S_ACCUM;
         S_ACCUM: if (r_idx == IDX_W'(N_CH - 1)) w_next = S_SCALE;
         S_SCALE: w_next = S_OUT;
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The strobe is registered once before the FSM sees it.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_strobe  <= 1'b0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_y       <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_pwm     <= {1'b1, {(PWM_W-1){1'b0}}};
      end else begin
         r_strobe <= mix_strobe;
         r_valid  <= 1'b0;
         if (r_strobe && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (r_strobe) begin
                  r_acc <= w_aux_ext;
                  r_idx <= '0;
               end
            end
            S_ACCUM: begin
               r_acc <= r_acc + w_term;
               r_idx <= r_idx + 1'b1;
            end
            S_SCALE: r_y <= w_ysat;
            S_OUT: begin
               r_pwm   <= {~r_y[PWM_W-1], r_y[PWM_W-2:0]};
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign mix_valid = r_valid;
   assign overrun   = r_overrun;
   assign pwm_out   = r_pwm;

endmodule
`default_nettype wire
